// File: rtl/nem_ohmux_sel_ctrl_pkg.sv
// Shared types, timing defaults and helpers for the NEM-relay select sequencer.
package nem_relay_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BREAK,
        MAKE
    } nem_state_e;

    localparam int NEM_BREAK_CYCLES_DEF = 3;
    localparam int NEM_MAKE_CYCLES_DEF  = 4;
    localparam int NEM_MAX_IN           = 16;

    // One-hot decode of idx over the maximum bank width; bits at or above n stay low.
    function automatic logic [NEM_MAX_IN-1:0] onehot(input logic [3:0] idx, input int n);
        logic [NEM_MAX_IN-1:0] oh;
        oh = '0;
        for (int k = 0; k < NEM_MAX_IN; k++) begin
            if (k < n && int'(idx) == k) oh[k] = 1'b1;
        end
        return oh;
    endfunction

endpackage

// File: rtl/nem_ohmux_sel_ctrl_if.sv
// Request handshake and select-bus signals between upstream, the sequencer and the relay bank.
interface nem_ohmux_sel_ctrl_if #(
    parameter int N_IN = 2
) ();
    localparam int SEL_W = $clog2(N_IN);

    logic             req_valid;
    logic [SEL_W-1:0] req_sel;
    logic             req_ready;
    logic [N_IN-1:0]  S;
    logic             sel_valid;
    logic [SEL_W-1:0] sel_cur;
    logic             done;
    logic             err;

    modport master (
        output req_valid, req_sel,
        input  req_ready, S, sel_valid, sel_cur, done, err
    );

    modport slave (
        input  req_valid, req_sel,
        output req_ready, S, sel_valid, sel_cur, done, err
    );
endinterface

// File: rtl/nem_ohmux_sel_ctrl_settle_timer.sv
// Load/decrement settle counter shared by the BREAK and MAKE phases; saturates at zero.
module nem_settle_timer #(
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o
);
    logic [CNT_W-1:0] cnt_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (dec_i && cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign zero_o = (cnt_q == '0);
endmodule

// File: rtl/nem_ohmux_sel_ctrl.sv
// Break-before-make sequencer for the one-hot select lines of an inverting NEM-relay mux bank.
module nem_ohmux_sel_ctrl
    import nem_relay_pkg::*;
#(
    parameter int N_IN         = 2,
    parameter int BREAK_CYCLES = NEM_BREAK_CYCLES_DEF,
    parameter int MAKE_CYCLES  = NEM_MAKE_CYCLES_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    nem_ohmux_sel_ctrl_if.slave   bus
);
    localparam int SEL_W   = $clog2(N_IN);
    localparam int MAX_CYC = (BREAK_CYCLES > MAKE_CYCLES) ? BREAK_CYCLES : MAKE_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);
    localparam logic [CNT_W-1:0] BREAK_LOAD = CNT_W'(BREAK_CYCLES - 1);
    localparam logic [CNT_W-1:0] MAKE_LOAD  = CNT_W'(MAKE_CYCLES - 1);

    nem_state_e       state_q;
    logic [N_IN-1:0]  s_q;
    logic             sel_valid_q;
    logic [SEL_W-1:0] sel_cur_q;
    logic [SEL_W-1:0] target_q;
    logic             done_q;
    logic             err_q;

    logic                  req_ready;
    logic                  accept;
    logic                  sel_oob;
    logic                  fast_path;
    logic                  start_break;
    logic                  tmr_zero;
    logic                  tmr_load;
    logic [CNT_W-1:0]      tmr_load_val;
    logic [NEM_MAX_IN-1:0] target_oh;

    assign req_ready   = (state_q == IDLE) && !reset;
    assign accept      = bus.req_valid && req_ready;
    assign sel_oob     = (32'(bus.req_sel) >= N_IN);
    assign fast_path   = sel_valid_q && (bus.req_sel == sel_cur_q);
    assign start_break = accept && !sel_oob && !fast_path;
    assign target_oh   = onehot(4'(target_q), N_IN);

    // The timer is reloaded at the start of each phase and counts down while busy.
    assign tmr_load     = start_break || (state_q == BREAK && tmr_zero);
    assign tmr_load_val = start_break ? BREAK_LOAD : MAKE_LOAD;

    nem_settle_timer #(.CNT_W(CNT_W)) u_timer (
        .clk        (clk),
        .reset      (reset),
        .load_i     (tmr_load),
        .load_val_i (tmr_load_val),
        .dec_i      (state_q != IDLE),
        .zero_o     (tmr_zero)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            s_q         <= '0;
            sel_valid_q <= 1'b0;
            sel_cur_q   <= '0;
            target_q    <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (accept && sel_oob) begin
                        err_q <= 1'b1;
                    end else if (accept && fast_path) begin
                        done_q <= 1'b1;
                    end else if (start_break) begin
                        target_q    <= bus.req_sel;
                        s_q         <= '0;
                        sel_valid_q <= 1'b0;
                        state_q     <= BREAK;
                    end
                end
                BREAK: begin
                    if (tmr_zero) begin
                        s_q       <= target_oh[N_IN-1:0];
                        sel_cur_q <= target_q;
                        state_q   <= MAKE;
                    end
                end
                MAKE: begin
                    if (tmr_zero) begin
                        sel_valid_q <= 1'b1;
                        done_q      <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.req_ready = req_ready;
    assign bus.S         = s_q;
    assign bus.sel_valid = sel_valid_q;
    assign bus.sel_cur   = sel_cur_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
endmodule

// File: tb/tb_nem_ohmux_sel_ctrl.sv
// Cycle-table bench for a 2-input sequencer plus hand sequences on a 3-input instance.
module tb_nem_ohmux_sel_ctrl;

    logic clk   = 1'b0;
    logic rst_a = 1'b1;
    logic rst_b = 1'b1;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    nem_ohmux_sel_ctrl_if #(.N_IN(2)) bus_a ();
    nem_ohmux_sel_ctrl_if #(.N_IN(3)) bus_b ();

    nem_ohmux_sel_ctrl #(.N_IN(2)) u_dut_a (
        .clk   (clk),
        .reset (rst_a),
        .bus   (bus_a)
    );

    nem_ohmux_sel_ctrl #(.N_IN(3)) u_dut_b (
        .clk   (clk),
        .reset (rst_b),
        .bus   (bus_b)
    );

    typedef struct {
        logic       rst;
        logic       v;
        logic       sel;
        logic       rdy;
        logic [1:0] s;
        logic       sv;
        logic       cur;
        logic       d;
        logic       e;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else n_pass++;
    endtask

    // Append n identical cycles to the table.
    task automatic add(input int n, input logic rst, input logic v, input logic sel,
                       input logic rdy, input logic [1:0] s, input logic sv,
                       input logic cur, input logic d, input logic e);
        for (int k = 0; k < n; k++) vecs.push_back('{rst, v, sel, rdy, s, sv, cur, d, e});
    endtask

    initial begin
        int cycles;

        bus_a.req_valid = 1'b0;
        bus_a.req_sel   = '0;
        bus_b.req_valid = 1'b0;
        bus_b.req_sel   = '0;

        //   n  rst v sel rdy S      sv cur d  e
        // Reset, then first request (sel=1) accepted at cycle 10.
        add( 1, 1, 0, 0,  0, 2'b00, 0, 0,  0, 0);
        add( 9, 0, 0, 0,  1, 2'b00, 0, 0,  0, 0);
        add( 1, 0, 1, 1,  1, 2'b00, 0, 0,  0, 0);
        add( 3, 0, 0, 0,  0, 2'b00, 0, 0,  0, 0);
        add( 4, 0, 0, 0,  0, 2'b10, 0, 1,  0, 0);
        add( 1, 0, 0, 0,  1, 2'b10, 1, 1,  1, 0);
        // Switch 1 -> 0 with a full break gap.
        add( 1, 0, 1, 0,  1, 2'b10, 1, 1,  0, 0);
        add( 3, 0, 0, 0,  0, 2'b00, 0, 1,  0, 0);
        add( 4, 0, 0, 0,  0, 2'b01, 0, 0,  0, 0);
        add( 1, 0, 0, 0,  1, 2'b01, 1, 0,  1, 0);
        // Fast path: re-request the settled input.
        add( 1, 0, 1, 0,  1, 2'b01, 1, 0,  0, 0);
        add( 1, 0, 0, 0,  1, 2'b01, 1, 0,  1, 0);
        add( 1, 0, 0, 0,  1, 2'b01, 1, 0,  0, 0);
        // Back-to-back held requests, each next one accepted in the done cycle.
        add( 1, 0, 1, 1,  1, 2'b01, 1, 0,  0, 0);
        add( 3, 0, 1, 0,  0, 2'b00, 0, 0,  0, 0);
        add( 4, 0, 1, 0,  0, 2'b10, 0, 1,  0, 0);
        add( 1, 0, 1, 0,  1, 2'b10, 1, 1,  1, 0);
        add( 3, 0, 1, 1,  0, 2'b00, 0, 1,  0, 0);
        add( 4, 0, 1, 1,  0, 2'b01, 0, 0,  0, 0);
        add( 1, 0, 1, 1,  1, 2'b01, 1, 0,  1, 0);
        add( 3, 0, 0, 0,  0, 2'b00, 0, 0,  0, 0);
        // Reset lands during MAKE: abort without done.
        add( 1, 0, 0, 0,  0, 2'b10, 0, 1,  0, 0);
        add( 1, 1, 0, 0,  0, 2'b10, 0, 1,  0, 0);
        add( 5, 0, 0, 0,  1, 2'b00, 0, 0,  0, 0);
        // First request after reset (sel=0) still breaks and makes.
        add( 1, 0, 1, 0,  1, 2'b00, 0, 0,  0, 0);
        add( 3, 0, 0, 0,  0, 2'b00, 0, 0,  0, 0);
        add( 4, 0, 0, 0,  0, 2'b01, 0, 0,  0, 0);
        add( 1, 0, 0, 0,  1, 2'b01, 1, 0,  1, 0);
        add( 1, 0, 0, 0,  1, 2'b01, 1, 0,  0, 0);

        repeat (2) @(posedge clk);
        rst_b = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            rst_a           = vecs[i].rst;
            bus_a.req_valid = vecs[i].v;
            bus_a.req_sel   = vecs[i].sel;
            #1;
            check($sformatf("row%0d req_ready", i), 32'(bus_a.req_ready), 32'(vecs[i].rdy));
            check($sformatf("row%0d S", i),         32'(bus_a.S),         32'(vecs[i].s));
            check($sformatf("row%0d sel_valid", i), 32'(bus_a.sel_valid), 32'(vecs[i].sv));
            check($sformatf("row%0d sel_cur", i),   32'(bus_a.sel_cur),   32'(vecs[i].cur));
            check($sformatf("row%0d done", i),      32'(bus_a.done),      32'(vecs[i].d));
            check($sformatf("row%0d err", i),       32'(bus_a.err),       32'(vecs[i].e));
            check($sformatf("row%0d popcount", i),  32'($countones(bus_a.S) <= 1), 32'(1));
        end

        // Three-input instance: legal request to input 2, then an out-of-range index.
        @(negedge clk);
        bus_b.req_valid = 1'b1;
        bus_b.req_sel   = 2'd2;
        #1;
        check("b accept ready", 32'(bus_b.req_ready), 32'(1));
        @(negedge clk);
        bus_b.req_valid = 1'b0;
        cycles = 1;
        while (!bus_b.done && cycles < 20) begin
            check($sformatf("b popcount c%0d", cycles), 32'($countones(bus_b.S) <= 1), 32'(1));
            @(negedge clk);
            cycles++;
        end
        check("b done latency", 32'(cycles), 32'(8));
        check("b settled S", 32'(bus_b.S), 32'(3'b100));
        check("b settled sel_valid", 32'(bus_b.sel_valid), 32'(1));
        check("b settled sel_cur", 32'(bus_b.sel_cur), 32'(2));

        bus_b.req_valid = 1'b1;
        bus_b.req_sel   = 2'd3;
        @(negedge clk);
        bus_b.req_valid = 1'b0;
        check("b oob err", 32'(bus_b.err), 32'(1));
        check("b oob no done", 32'(bus_b.done), 32'(0));
        check("b oob S", 32'(bus_b.S), 32'(3'b100));
        check("b oob sel_valid", 32'(bus_b.sel_valid), 32'(1));
        check("b oob sel_cur", 32'(bus_b.sel_cur), 32'(2));
        check("b oob ready", 32'(bus_b.req_ready), 32'(1));
        @(negedge clk);
        check("b err one cycle", 32'(bus_b.err), 32'(0));
        check("b oob still S", 32'(bus_b.S), 32'(3'b100));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
